// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
// Optional MMIO window is enabled by defining MEM_RESPONDER_MMIO_EN.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // True when a BRAM read latency fits the 2-bit wait counter.
    function automatic logic rd_lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_responder_mmio.sv
// MMIO window decode, output register and input read path.
// Instanced by mem_responder only when MEM_RESPONDER_MMIO_EN is defined.
module mmio_port
    import mem_responder_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              accept,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] mmio_in,
    output logic              hit_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic [DATA_W-1:0] mmio_out
);

    // Whole window from the base upward bypasses the BRAM.
    assign hit_c   = (addr >= MMIO_BASE);
    // The responder samples this into rsp_rdata on the accept edge.
    assign rdata_c = mmio_in;

    // Only the base address is backed by a register; other window stores are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mmio_out <= '0;
        end else if (accept && write && (addr == MMIO_BASE)) begin
            mmio_out <= wdata;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one fetch/load/store at a time onto BRAM port A.
// Define MEM_RESPONDER_MMIO_EN to decode the MMIO window at MMIO_BASE.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       RD_LAT    = 1,
    parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(MMIO_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_fetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              bram_wren,
    input  logic [DATA_W-1:0] bram_rdata,
    input  logic [DATA_W-1:0] mmio_in,
    output logic [DATA_W-1:0] mmio_out
);

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    // Reject latencies the 2-bit wait counter cannot express.
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_responder: RD_LAT=%0d outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
    end

    state_t            state;
    logic [1:0]        cnt;
    logic              fetch_q;
    logic              accept_c;
    logic              mmio_hit_c;
    logic [DATA_W-1:0] mmio_rdata_c;

    assign accept_c = req_valid && req_ready;

`ifdef MEM_RESPONDER_MMIO_EN
    mmio_port #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MMIO_BASE (MMIO_BASE)
    ) u_mmio (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept_c),
        .write    (req_write),
        .addr     (req_addr),
        .wdata    (req_wdata),
        .mmio_in  (mmio_in),
        .hit_c    (mmio_hit_c),
        .rdata_c  (mmio_rdata_c),
        .mmio_out (mmio_out)
    );
`else
    logic unused_mmio;

    assign mmio_hit_c   = 1'b0;
    assign mmio_rdata_c = '0;
    assign mmio_out     = '0;
    assign unused_mmio  = ^{mmio_in, MMIO_BASE};
`endif

    // Request FSM; the BRAM address/data registers double as the captured request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            instr_out  <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_wren  <= 1'b0;
            cnt        <= '0;
            fetch_q    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            bram_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_ready <= 1'b0;
                        fetch_q   <= req_fetch & ~req_write;
                        cnt       <= '0;
                        if (mmio_hit_c) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            if (!req_write) begin
                                rsp_rdata <= mmio_rdata_c;
                                if (req_fetch) begin
                                    instr_out <= mmio_rdata_c;
                                end
                            end
                        end else if (req_write) begin
                            state      <= WR;
                            bram_addr  <= req_addr;
                            bram_wdata <= req_wdata;
                            bram_wren  <= 1'b1;
                        end else begin
                            state     <= RD_WAIT;
                            bram_addr <= req_addr;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_CNT) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= bram_rdata;
                        bram_addr <= '0;
                        if (fetch_q) begin
                            instr_out <= bram_rdata;
                        end
                    end
                end
                WR: begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    bram_addr  <= '0;
                    bram_wdata <= '0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (RD_LAT=2 main instance
// plus an RD_LAT=1..4 sweep of four further instances).
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_fetch;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] instr_out;
    logic [15:0] bram_addr;
    logic [15:0] bram_wdata;
    logic        bram_wren;
    logic [15:0] bram_rdata;
    logic [15:0] mmio_in;
    logic [15:0] mmio_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int wren_cnt = 0;
    int rsp_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .RD_LAT    (2),
        .MMIO_BASE (16'hFF00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_fetch  (req_fetch),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .instr_out  (instr_out),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wren  (bram_wren),
        .bram_rdata (bram_rdata),
        .mmio_in    (mmio_in),
        .mmio_out   (mmio_out)
    );

    // BRAM model: 256 words (low address byte), preset contents plus written words,
    // one registered read stage so data is valid two cycles after the address.
    logic [255:0] written;
    logic [15:0]  wmem [256];
    logic [15:0]  rd_pipe;

    function automatic logic [15:0] bram_read(input logic [15:0] a);
        if (written[a[7:0]]) return wmem[a[7:0]];
        if (a[7:0] == 8'h10) return 16'h5A21;
        return 16'hC000 | a;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            written <= '0;
        end else if (bram_wren) begin
            written[bram_addr[7:0]] <= 1'b1;
            wmem[bram_addr[7:0]]    <= bram_wdata;
        end
        rd_pipe <= bram_read(bram_addr);
    end
    assign bram_rdata = rd_pipe;

    always @(posedge clk) begin
        if (bram_wren) wren_cnt <= wren_cnt + 1;
        if (rsp_valid) rsp_cnt  <= rsp_cnt + 1;
    end

    // RD_LAT sweep instances; each gets a read pipeline RD_LAT-1 stages deep.
    logic        sw_valid;
    logic [15:0] sw_addr;
    logic [3:0]  sw_ready;
    logic [3:0]  sw_rsp_valid;
    logic [3:0]  sw_wren;
    logic [15:0] sw_rsp_rdata [4];
    logic [15:0] sw_instr     [4];
    logic [15:0] sw_baddr     [4];
    logic [15:0] sw_bwdata    [4];
    logic [15:0] sw_brdata    [4];
    logic [15:0] sw_mmio_out  [4];

    function automatic logic [15:0] sw_read(input logic [15:0] a);
        return a ^ 16'h3C00;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned L = g + 1;
        logic [15:0] pipe [3];

        always @(posedge clk) begin
            pipe[0] <= sw_read(sw_baddr[g]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        if (L == 1) begin : g_comb
            assign sw_brdata[g] = sw_read(sw_baddr[g]);
        end else begin : g_pipe
            assign sw_brdata[g] = pipe[L-2];
        end

        mem_responder #(
            .ADDR_W (16),
            .DATA_W (16),
            .RD_LAT (L)
        ) u_sw (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (sw_valid),
            .req_ready  (sw_ready[g]),
            .req_write  (1'b0),
            .req_fetch  (1'b1),
            .req_addr   (sw_addr),
            .req_wdata  (16'h0000),
            .rsp_valid  (sw_rsp_valid[g]),
            .rsp_rdata  (sw_rsp_rdata[g]),
            .instr_out  (sw_instr[g]),
            .bram_addr  (sw_baddr[g]),
            .bram_wdata (sw_bwdata[g]),
            .bram_wren  (sw_wren[g]),
            .bram_rdata (sw_brdata[g]),
            .mmio_in    (16'h0000),
            .mmio_out   (sw_mmio_out[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic wr, input logic fe, input logic [15:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_fetch = fe;
        req_addr  = a;
        req_wdata = d;
    endtask

    int snap;
    int lat [4];

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_fetch = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mmio_in   = 16'h0000;
        sw_valid  = 1'b0;
        sw_addr   = '0;

        // Reset state
        step(); step(); step();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_bram", 32'({bram_wren, bram_addr, bram_wdata} != '0), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_instr", 32'(instr_out), 0);
        check("rst_mmio_out", 32'(mmio_out), 0);
        reset = 1'b1;
        step();
        check("ready_after_release", 32'(req_ready), 1);

        // Fetch from 0x0010: rsp_valid at cycle 3
        drive_req(1'b0, 1'b1, 16'h0010, 16'h0000);
        step();                                  // cycle 1
        req_valid = 1'b0;
        check("fetch_c1_ready", 32'(req_ready), 0);
        check("fetch_c1_addr", 32'(bram_addr), 32'h0010);
        check("fetch_c1_rsp", 32'(rsp_valid), 0);
        step();                                  // cycle 2
        check("fetch_c2_rsp", 32'(rsp_valid), 0);
        check("fetch_c2_ready", 32'(req_ready), 0);
        step();                                  // cycle 3
        check("fetch_c3_rsp", 32'(rsp_valid), 1);
        check("fetch_c3_ready", 32'(req_ready), 0);
        check("fetch_rdata", 32'(rsp_rdata), 32'h5A21);
        check("fetch_instr", 32'(instr_out), 32'h5A21);
        step();                                  // cycle 4
        check("fetch_c4_rsp", 32'(rsp_valid), 0);
        check("fetch_c4_ready", 32'(req_ready), 1);
        check("fetch_c4_addr", 32'(bram_addr), 0);

        // Store 0xBEEF to 0x0042
        snap = wren_cnt;
        drive_req(1'b1, 1'b0, 16'h0042, 16'hBEEF);
        step();                                  // cycle 1
        req_valid = 1'b0;
        check("st_c1_wren", 32'(bram_wren), 1);
        check("st_c1_addr", 32'(bram_addr), 32'h0042);
        check("st_c1_wdata", 32'(bram_wdata), 32'hBEEF);
        check("st_c1_rsp", 32'(rsp_valid), 0);
        step();                                  // cycle 2
        check("st_c2_wren", 32'(bram_wren), 0);
        check("st_c2_rsp", 32'(rsp_valid), 1);
        check("st_keeps_rdata", 32'(rsp_rdata), 32'h5A21);
        step();                                  // cycle 3
        check("st_c3_ready", 32'(req_ready), 1);
        check("st_wren_once", 32'(wren_cnt - snap), 1);

        // Load back 0x0042: instr_out untouched
        drive_req(1'b0, 1'b0, 16'h0042, 16'h0000);
        step(); req_valid = 1'b0;
        step(); step();                          // cycle 3
        check("ld_rsp", 32'(rsp_valid), 1);
        check("ld_rdata", 32'(rsp_rdata), 32'hBEEF);
        check("ld_instr_kept", 32'(instr_out), 32'h5A21);
        step();

        // Busy drop: second request held during RD_WAIT
        snap = rsp_cnt;
        drive_req(1'b0, 1'b0, 16'h0020, 16'h0000);
        step();                                  // cycle 1
        drive_req(1'b0, 1'b0, 16'h0030, 16'h0000);
        check("busy_c1_addr", 32'(bram_addr), 32'h0020);
        step();                                  // cycle 2
        check("busy_c2_addr", 32'(bram_addr), 32'h0020);
        step();                                  // cycle 3
        check("busy_c3_rsp", 32'(rsp_valid), 1);
        check("busy_first_rdata", 32'(rsp_rdata), 32'hC020);
        step();                                  // cycle 4: second accepted here
        check("busy_c4_ready", 32'(req_ready), 1);
        check("busy_c4_rsp", 32'(rsp_valid), 0);
        step();                                  // cycle 5
        req_valid = 1'b0;
        check("busy_c5_addr", 32'(bram_addr), 32'h0030);
        check("busy_c5_ready", 32'(req_ready), 0);
        step(); step();                          // cycle 7
        check("busy_second_rsp", 32'(rsp_valid), 1);
        check("busy_second_rdata", 32'(rsp_rdata), 32'hC030);
        step();
        check("busy_rsp_count", 32'(rsp_cnt - snap), 2);

`ifdef MEM_RESPONDER_MMIO_EN
        // MMIO store to base, then loads from inside the window
        snap = wren_cnt;
        drive_req(1'b1, 1'b0, 16'hFF00, 16'h00A5);
        step(); req_valid = 1'b0;                // cycle 1
        check("mmio_st_rsp", 32'(rsp_valid), 1);
        check("mmio_st_out", 32'(mmio_out), 32'h00A5);
        check("mmio_st_addr", 32'(bram_addr), 0);
        step();
        check("mmio_st_ready", 32'(req_ready), 1);
        check("mmio_st_no_wren", 32'(wren_cnt - snap), 0);
        mmio_in = 16'h1234;
        drive_req(1'b0, 1'b0, 16'hFF03, 16'h0000);
        step(); req_valid = 1'b0;
        check("mmio_ld_rsp", 32'(rsp_valid), 1);
        check("mmio_ld_rdata", 32'(rsp_rdata), 32'h1234);
        check("mmio_ld_instr_kept", 32'(instr_out), 32'h5A21);
        step();
        drive_req(1'b1, 1'b0, 16'hFF01, 16'h0077);
        step(); req_valid = 1'b0;
        check("mmio_st_other_rsp", 32'(rsp_valid), 1);
        check("mmio_st_other_out", 32'(mmio_out), 32'h00A5);
        step();
        mmio_in = 16'h4321;
        drive_req(1'b0, 1'b1, 16'hFF05, 16'h0000);
        step(); req_valid = 1'b0;
        check("mmio_fetch_instr", 32'(instr_out), 32'h4321);
        step();
`else
        // No MMIO: the window addresses fall through to the BRAM
        mmio_in = 16'h1234;
        drive_req(1'b1, 1'b0, 16'hFF00, 16'h00A5);
        step(); req_valid = 1'b0;                // cycle 1
        check("nommio_st_wren", 32'(bram_wren), 1);
        check("nommio_st_addr", 32'(bram_addr), 32'hFF00);
        step();
        check("nommio_st_rsp", 32'(rsp_valid), 1);
        step();
        check("nommio_out_zero", 32'(mmio_out), 0);
        drive_req(1'b0, 1'b0, 16'hFF00, 16'h0000);
        step(); req_valid = 1'b0;
        check("nommio_ld_c1_rsp", 32'(rsp_valid), 0);
        step(); step();
        check("nommio_ld_rsp", 32'(rsp_valid), 1);
        check("nommio_ld_rdata", 32'(rsp_rdata), 32'h00A5);
        step();
`endif

        // Reset in the middle of a read
        snap = rsp_cnt;
        drive_req(1'b0, 1'b1, 16'h0010, 16'h0000);
        step();                                  // cycle 1, RD_WAIT
        req_valid = 1'b0;
        check("rstmid_c1_addr", 32'(bram_addr), 32'h0010);
        reset = 1'b0;
        step();                                  // cycle 2, reset taken
        check("rstmid_rsp", 32'(rsp_valid), 0);
        check("rstmid_ready", 32'(req_ready), 0);
        check("rstmid_bram", 32'({bram_wren, bram_addr, bram_wdata} != '0), 0);
        check("rstmid_rdata", 32'(rsp_rdata), 0);
        check("rstmid_instr", 32'(instr_out), 0);
        check("rstmid_mmio_out", 32'(mmio_out), 0);
        reset = 1'b1;
        step();                                  // cycle 3
        check("rstmid_ready_after", 32'(req_ready), 1);
        check("rstmid_c3_rsp", 32'(rsp_valid), 0);
        step(); step();
        check("rstmid_no_rsp", 32'(rsp_cnt - snap), 0);

        // RD_LAT sweep: accept together, latency to rsp_valid must be RD_LAT+1
        for (int g = 0; g < 4; g++) begin
            lat[g] = 0;
            check($sformatf("sweep%0d_ready", g + 1), 32'(sw_ready[g]), 1);
        end
        sw_valid = 1'b1;
        sw_addr  = 16'h0077;
        step();
        sw_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            for (int g = 0; g < 4; g++) begin
                if (sw_rsp_valid[g] && lat[g] == 0) lat[g] = c;
            end
            step();
        end
        for (int g = 0; g < 4; g++) begin
            check($sformatf("sweep%0d_latency", g + 1), 32'(lat[g]), 32'(g + 2));
            check($sformatf("sweep%0d_rdata", g + 1), 32'(sw_rsp_rdata[g]), 32'h3C77);
            check($sformatf("sweep%0d_instr", g + 1), 32'(sw_instr[g]), 32'h3C77);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
